pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 99 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-hazard stalls by Tuse/Tnew, mult/div occupancy,
// and flush/redirect on exception or eret at M.
module pipe_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [1:0]  TuseRsD,
    input  logic [1:0]  TuseRtD,
    input  logic [4:0]  AwriteE,
    input  logic [4:0]  AwriteM,
    input  logic [1:0]  TnewE,
    input  logic [1:0]  TnewM,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        mdStartE,
    input  logic        mdIsDivE,
    input  logic        mdUseD,
    input  logic        excReqM,
    input  logic        eretM,
    output logic        stallF,
    output logic        stallD,
    output logic        clrD,
    output logic        clrE,
    output logic        clrM,
    output logic        clrW,
    output logic [1:0]  pcSel,
    output logic        mdBusy,
    output logic [31:0] stallCnt
);
    typedef enum logic {IDLE, BUSY} md_state_e;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    md_state_e   state_q, state_d;
    logic [3:0]  mdCnt_q, mdCnt_d;
    logic [31:0] stallCnt_q, stallCnt_d;
    logic        hzRs, hzRt, mdStall, flush, stall, mdIssue;

    // Tuse==3 can never be below a 2-bit Tnew, so "unused" falls out of the compare.
    always_comb begin
        hzRs = (rsD != 5'd0) && (TuseRsD != 2'd3) &&
               ((RegWriteE && AwriteE == rsD && TuseRsD < TnewE) ||
                (RegWriteM && AwriteM == rsD && TuseRsD < TnewM));
        hzRt = (rtD != 5'd0) && (TuseRtD != 2'd3) &&
               ((RegWriteE && AwriteE == rtD && TuseRtD < TnewE) ||
                (RegWriteM && AwriteM == rtD && TuseRtD < TnewM));
    end

    // An issue alongside an exception belongs to a cancelled instruction.
    assign mdIssue = mdStartE & ~excReqM;
    assign mdBusy  = (state_q == BUSY) | mdIssue;
    assign mdStall = mdUseD & mdBusy;
    assign flush   = excReqM | eretM;
    assign stall   = (hzRs | hzRt | mdStall) & ~flush;

    assign stallF   = stall;
    assign stallD   = stall;
    assign clrE     = stall | flush;
    assign clrD     = flush;
    assign clrM     = flush;
    assign clrW     = flush;
    assign pcSel    = excReqM ? 2'b01 : (eretM ? 2'b10 : 2'b00);
    assign stallCnt = stallCnt_q;

    always_comb begin
        state_d    = state_q;
        mdCnt_d    = mdCnt_q;
        stallCnt_d = stallCnt_q;
        case (state_q)
            IDLE: if (mdIssue) begin
                mdCnt_d = mdIsDivE ? DIV_LD : MULT_LD;
                state_d = BUSY;
            end
            BUSY: begin
                mdCnt_d = mdCnt_q - 4'd1;
                if (mdCnt_q == 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (stall && stallCnt_q != 32'hFFFF_FFFF) stallCnt_d = stallCnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mdCnt_q    <= 4'd0;
            stallCnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            mdCnt_q    <= mdCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rsD, rtD, AwriteE, AwriteM;
    logic [1:0]  TuseRsD, TuseRtD, TnewE, TnewM;
    logic        RegWriteE, RegWriteM, mdStartE, mdIsDivE, mdUseD, excReqM, eretM;
    logic        stallF, stallD, clrD, clrE, clrM, clrW, mdBusy;
    logic [1:0]  pcSel;
    logic [31:0] stallCnt;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .TuseRsD(TuseRsD), .TuseRtD(TuseRtD),
        .AwriteE(AwriteE), .AwriteM(AwriteM), .TnewE(TnewE), .TnewM(TnewM),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .mdStartE(mdStartE), .mdIsDivE(mdIsDivE),
        .mdUseD(mdUseD), .excReqM(excReqM), .eretM(eretM), .stallF(stallF), .stallD(stallD),
        .clrD(clrD), .clrE(clrE), .clrM(clrM), .clrW(clrW), .pcSel(pcSel), .mdBusy(mdBusy),
        .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    int      n_chk = 0, n_fail = 0;
    int      m_rem = 0;           // remaining BUSY cycles of the in-flight mult/div
    longint  m_cnt = 0;           // reference stall count
    int      busy_seen;
    bit      exp_stall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit hz(input logic [4:0] r, input logic [1:0] tuse);
        if (r == 0 || tuse == 3) return 0;
        return (RegWriteE && AwriteE == r && int'(tuse) < int'(TnewE)) ||
               (RegWriteM && AwriteM == r && int'(tuse) < int'(TnewM));
    endfunction

    // Check every output against the model at negedge, then advance the model at posedge.
    task automatic cycle();
        bit busy, flush;
        @(negedge clk);
        busy      = (m_rem > 0) || (mdStartE && !excReqM);
        flush     = excReqM || eretM;
        exp_stall = (hz(rsD, TuseRsD) || hz(rtD, TuseRtD) || (mdUseD && busy)) && !flush;
        chk("mdBusy",   32'(mdBusy), 32'(busy));
        chk("stallF",   32'(stallF), 32'(exp_stall));
        chk("stallD",   32'(stallD), 32'(exp_stall));
        chk("clrE",     32'(clrE),   32'(exp_stall || flush));
        chk("clrD",     32'(clrD),   32'(flush));
        chk("clrM",     32'(clrM),   32'(flush));
        chk("clrW",     32'(clrW),   32'(flush));
        chk("pcSel",    32'(pcSel),  excReqM ? 32'd1 : (eretM ? 32'd2 : 32'd0));
        chk("stallCnt", stallCnt,    32'(m_cnt));
        @(posedge clk);
        if (reset) begin
            m_rem = 0; m_cnt = 0;
        end else begin
            if (m_rem > 0) m_rem--;
            else if (mdStartE && !excReqM) m_rem = mdIsDivE ? 10 : 5;
            if (exp_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rsD = 0; rtD = 0; TuseRsD = 3; TuseRtD = 3; AwriteE = 0; AwriteM = 0;
        TnewE = 0; TnewM = 0; RegWriteE = 0; RegWriteM = 0; mdStartE = 0;
        mdIsDivE = 0; mdUseD = 0; excReqM = 0; eretM = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        cycle(); cycle();
        reset = 0;
        #1 chk("rst_cnt", stallCnt, 0);
        chk("rst_busy", 32'(mdBusy), 0);

        // lw $2 in E, D uses rs=2 next cycle
        RegWriteE = 1; AwriteE = 2; TnewE = 2; rsD = 2; TuseRsD = 1;
        #1 chk("lw_stall", 32'(stallF & stallD & clrE), 1);
        cycle();
        chk("lw_cnt", stallCnt, 1);
        // same producer in M with Tnew=0, then $0 producer
        RegWriteE = 0; RegWriteM = 1; AwriteM = 2; TnewM = 0;
        #1 chk("m_nostall", 32'(stallF), 0);
        cycle();
        RegWriteM = 0; RegWriteE = 1; AwriteE = 0; rsD = 0; TnewE = 2;
        #1 chk("r0_nostall", 32'(stallF), 0);
        cycle();
        idle_inputs();

        // mult then mfhi in D: busy for issue + 5 cycles
        mdStartE = 1; mdUseD = 1; busy_seen = 0;
        for (int i = 0; i < 9; i++) begin
            #1 if (mdBusy) busy_seen++;
            cycle();
            mdStartE = 0;
        end
        chk("mult_busy_cycles", busy_seen, 6);
        chk("mult_release", 32'(stallF), 0);
        idle_inputs();

        // div, exception on third BUSY cycle; divide still finishes
        mdStartE = 1; mdIsDivE = 1; busy_seen = 0;
        for (int i = 0; i < 14; i++) begin
            excReqM = (i == 3);
            mdUseD  = (i == 3);
            #1 if (mdBusy) busy_seen++;
            if (i == 3) begin
                chk("exc_pcSel", 32'(pcSel), 1);
                chk("exc_clr", 32'({clrD, clrE, clrM, clrW}), 32'hF);
                chk("exc_nostall", 32'(stallF), 0);
                chk("exc_busy", 32'(mdBusy), 1);
            end
            cycle();
            mdStartE = 0;
        end
        chk("div_busy_cycles", busy_seen, 11);
        idle_inputs();

        // issue cancelled by a same-cycle exception
        mdStartE = 1; excReqM = 1;
        cycle();
        idle_inputs();
        #1 chk("cancel_busy", 32'(mdBusy), 0);
        cycle();

        excReqM = 1; eretM = 1;
        #1 chk("exc_prio", 32'(pcSel), 1);
        cycle();
        excReqM = 0;
        #1 chk("eret_sel", 32'(pcSel), 2);
        cycle();
        idle_inputs();

        // reset mid-divide with stalls accumulating
        mdStartE = 1; mdIsDivE = 1;
        cycle();
        mdStartE = 0; mdUseD = 1;
        cycle(); cycle();
        reset = 1;
        cycle();
        reset = 0; mdUseD = 0;
        #1 chk("rst_mid_cnt", stallCnt, 0);
        chk("rst_mid_busy", 32'(mdBusy), 0);

        // random traffic with a small register pool to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
            TuseRsD = 2'($urandom); TuseRtD = 2'($urandom);
            AwriteE = 5'($urandom_range(0, 3)); AwriteM = 5'($urandom_range(0, 3));
            TnewE = 2'($urandom); TnewM = 2'($urandom);
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom);
            mdStartE = ($urandom_range(0, 7) == 0); mdIsDivE = 1'($urandom);
            mdUseD = 1'($urandom);
            excReqM = ($urandom_range(0, 15) == 0); eretM = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
